// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, reads Instmem combinationally and buffers
// fetched words in a 2-entry FIFO (head register + one tail slot) towards decode.
module if_stage #(
    parameter int          ADDR_WIDTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          PC_STEP    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [31:0]           imem_value,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [31:0]           out_pc,
    output logic                  fault,
    output logic [31:0]           fault_pc
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } state_t;

    state_t      state;
    logic [31:0] pc;

    // The head entry lives directly in the output registers; the tail slot
    // only holds a word while the head is stalled by decode.
    logic        tl_valid;
    logic [31:0] tl_instr;
    logic [31:0] tl_pc;

    logic pop;
    logic full;
    logic push;

    assign imem_address = pc[ADDR_WIDTH-1:0];
    assign pop          = out_valid && out_ready;
    assign full         = out_valid && tl_valid;
    assign push         = (state == RUN) && !redirect_valid && (!full || pop);

    // NOTE: every register here is state, so it is assigned with <= only; the
    // async reset clears the data registers too so decode sees zeros at reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            tl_valid  <= 1'b0;
            tl_instr  <= '0;
            tl_pc     <= '0;
            fault     <= 1'b0;
            fault_pc  <= '0;
        end else if (state == IDLE) begin
            state <= RUN;
        end else if (redirect_valid) begin
            // Flush both entries; data registers keep their stale contents.
            out_valid <= 1'b0;
            tl_valid  <= 1'b0;
            pc        <= redirect_pc;
            if (redirect_pc[1:0] == 2'b00) begin
                state <= RUN;
                fault <= 1'b0;
            end else begin
                state    <= FAULT;
                fault    <= 1'b1;
                fault_pc <= redirect_pc;
            end
        end else begin
            if (push) begin
                pc <= pc + 32'(PC_STEP);
            end
            if (pop || !out_valid) begin
                if (tl_valid) begin
                    out_valid <= 1'b1;
                    out_instr <= tl_instr;
                    out_pc    <= tl_pc;
                    tl_valid  <= push;
                    if (push) begin
                        tl_instr <= imem_value;
                        tl_pc    <= pc;
                    end
                end else if (push) begin
                    out_valid <= 1'b1;
                    out_instr <= imem_value;
                    out_pc    <= pc;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (push) begin
                tl_valid <= 1'b1;
                tl_instr <= imem_value;
                tl_pc    <= pc;
            end
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined riscv32i core, directly upstream of Instmem.
- Owns the program counter and drives the byte address into Instmem's combinational read port.
- Captures each returned 32-bit word with its PC into a 2-entry fetch queue.
- Presents the queue head to decode through a valid/ready handshake; accepts PC redirects from later stages and reports misaligned redirect targets.

Parameters:
ADDR_WIDTH, 4, width of imem_address; the PC is truncated to this width when driving the memory.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, PC increment per fetched instruction.

Ports:
clock  input  1  single clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
imem_address  output  ADDR_WIDTH  byte address to Instmem, equal to pc[ADDR_WIDTH-1:0]
imem_value  input  32  instruction word from Instmem, combinational from imem_address
redirect_valid  input  1  load a new PC and flush the queue
redirect_pc  input  32  redirect target
out_valid  output  1  queue head is valid
out_ready  input  1  decode accepts the head this cycle
out_instr  output  32  head instruction
out_pc  output  32  head PC
fault  output  1  misaligned-target fault is active
fault_pc  output  32  offending redirect target

Behaviour:
- Reset (reset==0, asynchronous):
  - pc=RESET_PC, queue count=0, state=IDLE.
  - out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0.
  - imem_address=RESET_PC[ADDR_WIDTH-1:0].
  - Asserting reset mid-operation takes effect immediately; queue contents are discarded.
- States:
  - IDLE: no fetch. At the first edge after reset deassertion, go to RUN.
  - RUN: normal fetch.
  - FAULT: fetching stopped; pc holds; queue stays empty.
- pop = out_valid && out_ready.
- push (RUN only, no redirect this cycle) = (count<2) || (count==2 && pop).
  - On push: the entry {imem_value, pc} is written at the tail, and pc <= pc + PC_STEP (32-bit, wraps modulo 2^32).
  - imem_address wraps naturally through truncation.
- Outputs and latency:
  - out_instr and out_pc come from the head register, i.e. registered outputs.
  - A word fetched at edge N is visible on the outputs after edge N; one cycle of latency.
  - Queue order is strictly FIFO; no entry is lost or duplicated.
  - Count update: push and pop together leave count unchanged.
- Backpressure: with out_ready=0 and count==2, push=0, so pc and imem_address hold.
- Redirect (redirect_valid==1 at an edge, any state except IDLE):
  - count <= 0 and pc <= redirect_pc; any pop that cycle is still considered accepted by decode.
  - No push in that cycle.
  - Redirect has priority over push.
  - If redirect_pc[1:0]==2'b00: state <= RUN and fault <= 0.
  - Otherwise: state <= FAULT, fault <= 1, fault_pc <= redirect_pc, and out_valid stays 0.
- After an aligned redirect, out_valid is 0 for exactly one cycle (the bubble); the new target's word appears after the next edge.
- FAULT: only an aligned redirect exits FAULT. A misaligned redirect in FAULT updates fault_pc.
- When out_valid==0, out_instr and out_pc hold their last values; decode must not sample them.

Test Plan:
1. Instmem little-endian, memory[i]=8'h11*i, out_ready=1, release reset.
   -> One IDLE cycle, then out_valid=1 with out_pc=0, out_instr=32'h33221100.
   -> Next cycle out_pc=4, out_instr=32'h77665544.
2. Hold out_ready=0 for 5 cycles after the first valid.
   -> count saturates at 2, out_pc stays 0, imem_address stays 8.
   -> Raise out_ready: out_pc sequence 0, 4, 8 with no gap, loss or duplicate.
3. Queue full (heads pc 0, 4); pulse redirect_valid with redirect_pc=4.
   -> Following cycle out_valid=0.
   -> Then out_pc=4, out_instr=32'h77665544; old entries never reappear.
4. Redirect to 32'h6.
   -> fault=1, fault_pc=6, out_valid=0, imem_address frozen at 6 for 4+ cycles.
   -> Then redirect to 0: fault=0, out_pc=0 after one bubble.
5. Assert reset between edges while out_valid=1.
   -> out_valid, fault, out_pc drop to 0 immediately, without waiting for an edge.
   -> Release: IDLE then refetch from pc 0.
6. Same edge with out_ready=1, count=2 and redirect_valid=1, redirect_pc=8.
   -> Redirect wins: count=0, pc=8, no push; next valid out_pc=8.
